// File: rtl/memwr_pkg.sv
// Shared types and defaults for the SDRAM write coalescer: FSM state encoding,
// default geometry and the address contiguity/boundary rule.
package memwr_pkg;

  localparam int DEF_AW      = 25;
  localparam int DEF_DW      = 16;
  localparam int DEF_BURST   = 8;
  localparam int DEF_LW      = 4;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    CMD  = 2'd2,
    DATA = 2'd3
  } state_e;

  // True when addr continues the run starting at base (mod 2^aw) and does not
  // sit on a burst-aligned boundary, so it may join the current burst.
  function automatic logic addr_joins(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] cnt,
                                      input int          aw,
                                      input int          burst);
    logic [63:0] mask;
    mask = (aw >= 64) ? '1 : ((64'd1 << aw) - 64'd1);
    return ((((base + cnt) ^ addr) & mask) == 64'd0) &&
           ((addr & 64'(burst - 1)) != 64'd0);
  endfunction

endpackage

// File: rtl/wr_burst_buf.sv
// BURST x DW gather buffer: one write-at-index port, one registered read port
// whose output register clears on reset.
module wr_burst_buf #(
  parameter int DW    = 16,
  parameter int BURST = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(BURST)-1:0] wr_idx_i,
  input  logic [DW-1:0]            wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(BURST)-1:0] rd_idx_i,
  output logic [DW-1:0]            rd_data_o
);

  logic [DW-1:0] mem_q [BURST];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mem_wr_coalescer.sv
// Gathers address-contiguous single-word writes into SDRAM bursts.
// Optional counters stat_bursts/stat_words under `MEMWR_COALESCER_STATS_EN.
module mem_wr_coalescer
  import memwr_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int BURST   = DEF_BURST,
  parameter int LW      = DEF_LW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          mem_clk,
  input  logic          rst,
  input  logic          in_wr_req,
  input  logic [AW-1:0] in_wr_addr,
  input  logic [DW-1:0] in_wr_data,
  output logic          in_ack,
  output logic          in_idle,
  input  logic          flush,
  output logic          sdr_wr_req,
  output logic [AW-1:0] sdr_wr_addr,
  output logic [LW-1:0] sdr_wr_len,
  input  logic          sdr_ack,
  input  logic          sdr_data_next,
  output logic [DW-1:0] sdr_wr_data,
  output logic          err_overrun
`ifdef MEMWR_COALESCER_STATS_EN
  ,
  output logic [15:0]   stat_bursts,
  output logic [23:0]   stat_words
`endif
);

  localparam int IW = $clog2(BURST);
  localparam int CW = $clog2(BURST + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] base_q, base_d;
  logic [15:0]   timer_q, timer_d;
  logic          ack_prev_q;
  logic          err_q;
  logic          accept;
  logic          req_live;
  logic          addr_ok;

  // Handshake: upstream holds in_wr_req with addr/data until it sees in_ack
  // high; the word is taken on the edge closing that cycle. A request seen the
  // cycle right after an ack is treated as stale and neither accepted nor
  // used as a flush trigger.
  assign req_live = in_wr_req && !ack_prev_q;
  assign addr_ok  = addr_joins(64'(in_wr_addr), 64'(base_q), 64'(cnt_q), AW, BURST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    timer_d  = timer_q;
    rd_ptr_d = rd_ptr_q;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_live) begin
          accept  = 1'b1;
          base_d  = in_wr_addr;
          cnt_d   = CW'(1);
          timer_d = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (flush) begin
          state_d = CMD;
        end else if (req_live && addr_ok) begin
          accept  = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          timer_d = '0;
          if (cnt_d == CW'(BURST)) state_d = CMD;
        end else if (req_live) begin
          state_d = CMD;
        end else if (timer_q == 16'(TIMEOUT - 1)) begin
          state_d = CMD;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      CMD: begin
        if (sdr_ack) begin
          rd_ptr_d = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (sdr_data_next) begin
          rd_ptr_d = rd_ptr_q + CW'(1);
          if (rd_ptr_d == cnt_q) begin
            rd_ptr_d = '0;
            cnt_d    = '0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      base_q     <= '0;
      timer_q    <= '0;
      ack_prev_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      base_q     <= base_d;
      timer_q    <= timer_d;
      ack_prev_q <= in_ack;
      if (sdr_data_next && state_q != DATA) err_q <= 1'b1;
    end
  end

  // The read register follows the next pointer so the word for rd_ptr is
  // already on sdr_wr_data in the first DATA cycle.
  wr_burst_buf #(
    .DW    (DW),
    .BURST (BURST)
  ) u_buf (
    .clk_i     (mem_clk),
    .rst_i     (rst),
    .wr_en_i   (in_ack),
    .wr_idx_i  (cnt_q[IW-1:0]),
    .wr_data_i (in_wr_data),
    .rd_en_i   (state_d == DATA),
    .rd_idx_i  (rd_ptr_d[IW-1:0]),
    .rd_data_o (sdr_wr_data)
  );

  assign in_ack      = accept && !rst;
  assign in_idle     = (state_q == IDLE);
  assign sdr_wr_req  = (state_q == CMD);
  assign sdr_wr_addr = base_q;
  assign sdr_wr_len  = LW'(cnt_q);
  assign err_overrun = err_q;

`ifdef MEMWR_COALESCER_STATS_EN
  logic [15:0] bursts_q;
  logic [23:0] words_q;
  logic [24:0] words_sum;

  assign words_sum = {1'b0, words_q} + 25'(cnt_q);

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      bursts_q <= '0;
      words_q  <= '0;
    end else if (state_q == CMD && sdr_ack) begin
      bursts_q <= (&bursts_q) ? bursts_q : bursts_q + 16'd1;
      words_q  <= words_sum[24] ? '1 : words_sum[23:0];
    end
  end

  assign stat_bursts = bursts_q;
  assign stat_words  = words_q;
`endif

endmodule

// File: tb/tb_mem_wr_coalescer.sv
// Directed bench for mem_wr_coalescer: upstream driver, SDRAM responder and a
// burst scoreboard with hand-computed expectations.
module tb_mem_wr_coalescer;

  logic        mem_clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_wr_req = 1'b0;
  logic [24:0] in_wr_addr = '0;
  logic [15:0] in_wr_data = '0;
  logic        flush = 1'b0;
  logic        sdr_ack;
  logic        sdr_data_next;
  logic        in_ack;
  logic        in_idle;
  logic        sdr_wr_req;
  logic [24:0] sdr_wr_addr;
  logic [3:0]  sdr_wr_len;
  logic [15:0] sdr_wr_data;
  logic        err_overrun;
`ifdef MEMWR_COALESCER_STATS_EN
  logic [15:0] stat_bursts;
  logic [23:0] stat_words;
`endif

  mem_wr_coalescer dut (
    .mem_clk       (mem_clk),
    .rst           (rst),
    .in_wr_req     (in_wr_req),
    .in_wr_addr    (in_wr_addr),
    .in_wr_data    (in_wr_data),
    .in_ack        (in_ack),
    .in_idle       (in_idle),
    .flush         (flush),
    .sdr_wr_req    (sdr_wr_req),
    .sdr_wr_addr   (sdr_wr_addr),
    .sdr_wr_len    (sdr_wr_len),
    .sdr_ack       (sdr_ack),
    .sdr_data_next (sdr_data_next),
    .sdr_wr_data   (sdr_wr_data),
    .err_overrun   (err_overrun)
`ifdef MEMWR_COALESCER_STATS_EN
    ,
    .stat_bursts   (stat_bursts),
    .stat_words    (stat_words)
`endif
  );

  always #5 mem_clk = ~mem_clk;

  int n_checks = 0;
  int n_pass = 0;

  // Expected bursts (scoreboard) and what the responder observed.
  logic [24:0] exp_addr_q[$];
  logic [3:0]  exp_len_q[$];
  logic [15:0] exp_data_q[$];
  logic [24:0] got_addr_q[$];
  logic [3:0]  got_len_q[$];
  logic [15:0] got_data_q[$];
  int got_b = 0;
  int got_w = 0;

  // Responder state; only the responder process writes these.
  int   req_seen, words_left, data_sent, extra_done, req_after_ack;
  logic just_acked;
  // Responder knobs; only the main process writes these.
  int data_limit = 32'h7fffffff;
  int extra_req_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // SDRAM controller model: acks a command on its third cycle, then pulls
  // one word per cycle until the burst length or data_limit is reached.
  initial begin
    sdr_ack = 1'b0; sdr_data_next = 1'b0;
    req_seen = 0; words_left = 0; data_sent = 0; extra_done = 0;
    req_after_ack = 0; just_acked = 1'b0;
    forever begin
      @(negedge mem_clk);
      sdr_ack = 1'b0;
      sdr_data_next = 1'b0;
      if (just_acked && sdr_wr_req) req_after_ack++;
      just_acked = 1'b0;
      if (rst) begin
        req_seen = 0;
        words_left = 0;
      end else if (extra_done != extra_req_cnt) begin
        sdr_data_next = 1'b1;
        extra_done++;
      end else if (words_left > 0) begin
        if (data_sent < data_limit) begin
          sdr_data_next = 1'b1;
          got_data_q.push_back(sdr_wr_data);
          words_left--;
          data_sent++;
        end
      end else if (sdr_wr_req) begin
        req_seen++;
        if (req_seen == 3) begin
          sdr_ack = 1'b1;
          got_addr_q.push_back(sdr_wr_addr);
          got_len_q.push_back(sdr_wr_len);
          words_left = int'(sdr_wr_len);
          req_seen = 0;
          just_acked = 1'b1;
        end
      end
    end
  end

  task automatic push_word(input logic [24:0] a, input logic [15:0] d);
    int n;
    @(negedge mem_clk);
    in_wr_req = 1'b1; in_wr_addr = a; in_wr_data = d;
    n = 0;
    #1;
    while (!in_ack && n < 300) begin
      @(negedge mem_clk);
      #1;
      n++;
    end
    chk("ack_wait", 32'(n < 300), 32'd1);
    @(negedge mem_clk);
    in_wr_req = 1'b0;
  endtask

  task automatic push_run(input logic [24:0] a0, input int n, input logic [15:0] d0);
    for (int i = 0; i < n; i++) push_word(a0 + 25'(i), d0 + 16'(i));
  endtask

  task automatic expect_burst(input logic [24:0] a, input int len, input logic [15:0] d0,
                              input int nwords);
    exp_addr_q.push_back(a);
    exp_len_q.push_back(4'(len));
    for (int i = 0; i < nwords; i++) exp_data_q.push_back(d0 + 16'(i));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(in_idle && !sdr_wr_req && words_left == 0) && n < 400) begin
      @(negedge mem_clk);
      n++;
    end
    chk(tag, 32'(n < 400), 32'd1);
  endtask

  task automatic check_bursts();
    while (exp_addr_q.size() > 0) begin
      if (got_b >= got_addr_q.size()) begin
        chk("burst_present", 32'd0, 32'd1);
        exp_addr_q.delete();
        exp_len_q.delete();
        break;
      end
      chk("burst_addr", 32'(got_addr_q[got_b]), 32'(exp_addr_q.pop_front()));
      chk("burst_len", 32'(got_len_q[got_b]), 32'(exp_len_q.pop_front()));
      got_b++;
    end
    while (exp_data_q.size() > 0) begin
      if (got_w >= got_data_q.size()) begin
        chk("data_present", 32'd0, 32'd1);
        exp_data_q.delete();
        break;
      end
      chk("burst_data", 32'(got_data_q[got_w]), 32'(exp_data_q.pop_front()));
      got_w++;
    end
    chk("burst_count", 32'(got_addr_q.size()), 32'(got_b));
  endtask

  // Holds rst across one rising edge and one falling edge, then checks the
  // outputs while the reset values must already be visible.
  task automatic do_reset(input string tag);
    @(negedge mem_clk);
    #1 rst = 1'b1;
    @(posedge mem_clk);
    @(negedge mem_clk);
    #1;
    chk({tag, "_in_ack"}, 32'(in_ack), 32'd0);
    chk({tag, "_sdr_wr_req"}, 32'(sdr_wr_req), 32'd0);
    chk({tag, "_sdr_wr_addr"}, 32'(sdr_wr_addr), 32'd0);
    chk({tag, "_sdr_wr_len"}, 32'(sdr_wr_len), 32'd0);
    chk({tag, "_sdr_wr_data"}, 32'(sdr_wr_data), 32'd0);
    chk({tag, "_err_overrun"}, 32'(err_overrun), 32'd0);
    chk({tag, "_in_idle"}, 32'(in_idle), 32'd1);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int nb;

    do_reset("rst0");

    // A flush with nothing buffered must not create a burst.
    @(negedge mem_clk); flush = 1'b1;
    @(negedge mem_clk); flush = 1'b0;
    repeat (5) @(negedge mem_clk);
    chk("empty_flush_idle", 32'(in_idle), 32'd1);
    chk("empty_flush_bursts", 32'(got_addr_q.size()), 32'd0);

    // Full aligned burst of 8.
    push_run(25'h10, 8, 16'h0000);
    expect_burst(25'h10, 8, 16'h0000, 8);
    wait_idle("idle_full");
    chk("idle_after_full", 32'(in_idle), 32'd1);
    check_bursts();
    chk("req_drop_after_ack", 32'(req_after_ack), 32'd0);
    chk("no_overrun_yet", 32'(err_overrun), 32'd0);

    // Partial burst flushed by the idle timer after 64 cycles.
    push_run(25'h20, 3, 16'h2000);
    n = 0;
    while (!sdr_wr_req && n < 200) begin
      @(negedge mem_clk);
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd64);
    expect_burst(25'h20, 3, 16'h2000, 3);
    wait_idle("idle_timeout");
    check_bursts();

    // Non-contiguous address flushes the run before it is accepted.
    push_run(25'h30, 2, 16'h3000);
    nb = got_addr_q.size();
    push_word(25'h50, 16'h5000);
    chk("split_before_ack", 32'(got_addr_q.size()), 32'(nb + 1));
    expect_burst(25'h30, 2, 16'h3000, 2);
    expect_burst(25'h50, 1, 16'h5000, 1);
    wait_idle("idle_noncontig");
    check_bursts();

    // Burst-aligned boundary splits an otherwise contiguous run.
    push_run(25'h06, 3, 16'h0600);
    expect_burst(25'h06, 2, 16'h0600, 2);
    expect_burst(25'h08, 1, 16'h0602, 1);
    wait_idle("idle_boundary");
    check_bursts();

    // Reset after two of eight words have streamed.
    data_limit = data_sent + 2;
    push_run(25'h60, 8, 16'h6000);
    n = 0;
    while (data_sent < data_limit && n < 200) begin
      @(negedge mem_clk);
      n++;
    end
    chk("partial_stream", 32'(data_sent == data_limit), 32'd1);
    @(negedge mem_clk);
    chk("stalled_in_data", 32'(in_idle), 32'd0);
    expect_burst(25'h60, 8, 16'h6000, 2);
    do_reset("rst_mid");
    data_limit = 32'h7fffffff;
    check_bursts();

    // Single word after reset, pushed out by an explicit flush.
    push_word(25'h40, 16'h4040);
    @(negedge mem_clk); flush = 1'b1;
    @(negedge mem_clk); flush = 1'b0;
    expect_burst(25'h40, 1, 16'h4040, 1);
    wait_idle("idle_flush");
    check_bursts();
    chk("no_overrun_before_extra", 32'(err_overrun), 32'd0);

    // A data pull outside DATA sets the sticky overrun flag.
    extra_req_cnt++;
    repeat (3) @(negedge mem_clk);
    chk("overrun_set", 32'(err_overrun), 32'd1);
    repeat (5) @(negedge mem_clk);
    chk("overrun_sticky", 32'(err_overrun), 32'd1);
    chk("overrun_still_idle", 32'(in_idle), 32'd1);
    do_reset("rst_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
